// File: rtl/seq_fsm_pattern_tx_pkg.sv
// Shared types and widths for the serial pattern transmitter.
// Holds the FSM state encoding and the repeat-counter width.
// No logic, so it adds no latency and applies no backpressure.
package seq_fsm_pattern_tx_pkg;

    localparam int REPS_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_fsm_pattern_tx_ctr.sv
// Loadable up-counter with clear, increment and a terminal compare against limit.
// Updates one cycle after a command; the at_limit output is combinational from the count.
// Never stalls: priority is clr, then ld, then inc.
module seq_fsm_pattern_tx_ctr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == limit);

endmodule

// File: rtl/seq_fsm_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern LSB first, reps+1 times with one zero between frames.
// The first bit appears one cycle after the handshake; the done pulse follows the final bit.
// Ready is high only in IDLE; inputs are ignored for the whole transfer.
module seq_fsm_pattern_tx
    import seq_fsm_pattern_tx_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     istream_val,
    output logic                     istream_rdy,
    input  logic [nbits-1:0]         istream_msg,
    input  logic [$clog2(nbits)-1:0] istream_len,
    input  logic [REPS_W-1:0]        istream_reps,
    output logic                     out_,
    output logic                     out_val,
    output logic                     done,
    output logic [1:0]               state
);

    localparam int LEN_W = $clog2(nbits);

    state_t              state_q;
    state_t              state_d;
    logic [nbits-1:0]    pat_q;
    logic [LEN_W-1:0]    len_q;
    logic [REPS_W-1:0]   reps_q;
    logic [LEN_W-1:0]    idx;
    logic [REPS_W-1:0]   rep_cnt;
    logic                idx_last;
    logic                rep_last;
    logic                accept;
    logic                frame_end;

    assign accept    = (state_q == IDLE) && istream_val;
    assign frame_end = (state_q == SEND) && idx_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            reps_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                pat_q  <= istream_msg;
                len_q  <= istream_len;
                reps_q <= istream_reps;
            end
        end
    end

    // idx restarts both on a new transfer and at the end of every non-final frame
    seq_fsm_pattern_tx_ctr #(.W(LEN_W)) u_idx_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept || (frame_end && !rep_last)),
        .ld       (1'b0),
        .ld_val   ({LEN_W{1'b0}}),
        .inc      ((state_q == SEND) && !idx_last),
        .limit    (len_q),
        .cnt      (idx),
        .at_limit (idx_last)
    );

    seq_fsm_pattern_tx_ctr #(.W(REPS_W)) u_rep_ctr (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .ld       (1'b0),
        .ld_val   ({REPS_W{1'b0}}),
        .inc      (frame_end && !rep_last),
        .limit    (reps_q),
        .cnt      (rep_cnt),
        .at_limit (rep_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = SEND;
            SEND: if (idx_last) state_d = rep_last ? DONE : GAP;
            GAP:  state_d = SEND;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        istream_rdy = 1'b0;
        out_val     = 1'b0;
        out_        = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: istream_rdy = 1'b1;
            SEND: begin
                out_val = 1'b1;
                out_    = pat_q[idx];
            end
            GAP:  out_val = 1'b1;
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
